// File: rtl/riscv_pkg.sv
// Shared constants and enumerations for the load/store unit and its helpers.
// Funct3 codes double as store codes: SB=LB, SH=LH, SW=LW.
package riscv_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 10;
    localparam int ROM_DEPTH      = 256;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: load extension from the memory word and
// byte/half merge into the old word for partial stores.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/half lane and extend it for the load result
    always_comb begin
        byte_s     = 8'h00;
        half_s     = 16'h0000;
        load_value = {DATA_WIDTH{1'b0}};
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (lsu_funct3_e'(funct3))
            LB:      load_value = {{24{byte_s[7]}}, byte_s};
            LH:      load_value = {{16{half_s[15]}}, half_s};
            LBU:     load_value = {24'h000000, byte_s};
            LHU:     load_value = {16'h0000, half_s};
            default: load_value = rdata;
        endcase
    end

    // Merge the store byte/half into the previously read word
    always_comb begin
        store_word = old_word;
        case (funct3[1:0])
            2'b00: begin
                case (addr_lo)
                    2'b00:   store_word[7:0]   = wdata[7:0];
                    2'b01:   store_word[15:8]  = wdata[7:0];
                    2'b10:   store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, fault screening at accept,
// read-modify-write for sub-word stores, single-cycle registered response.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int RISC_V_DATA_WIDTH         = DATA_WIDTH,
    parameter int DATA_MEMORY_ADDRESS_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_MEMORY_ROM_DEPTH     = ROM_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_we,
    input  logic [2:0]                           req_funct3,
    input  logic [31:0]                          req_addr,
    input  logic [RISC_V_DATA_WIDTH-1:0]         req_wdata,
    output logic                                 rsp_valid,
    output logic [RISC_V_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                                 rsp_fault,
    output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] mem_address,
    output logic [RISC_V_DATA_WIDTH-1:0]         mem_w_data,
    input  logic [RISC_V_DATA_WIDTH-1:0]         mem_r_data,
    output logic                                 mem_ctrl_mem_w,
    output logic                                 mem_ctrl_mem_r
);

    localparam int AW = DATA_MEMORY_ADDRESS_WIDTH;
    localparam logic [AW-1:0] ROM_LIMIT = AW'(DATA_MEMORY_ROM_DEPTH);

    lsu_state_e                   state_r;
    logic                         req_ready_r;
    logic                         rsp_valid_r;
    logic [RISC_V_DATA_WIDTH-1:0] rsp_rdata_r;
    logic                         rsp_fault_r;
    logic [AW-1:0]                mem_address_r;
    logic [RISC_V_DATA_WIDTH-1:0] mem_w_data_r;
    logic                         mem_w_r;
    logic                         mem_r_r;
    logic                         we_r;
    logic [2:0]                   funct3_r;
    logic [1:0]                   addr_lo_r;
    logic [RISC_V_DATA_WIDTH-1:0] wdata_r;
    logic                         fault_s;
    logic [DATA_WIDTH-1:0]        load_value_s;
    logic [DATA_WIDTH-1:0]        store_word_s;

    // Any illegal direction/funct3 pair, misalignment, range or ROM-store violation
    function automatic logic lsu_fault(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        logic rom_store;
        bad_f3       = we ? (f3[2] || (f3[1:0] == 2'b11))
                          : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = |addr[31:AW+2];
        rom_store    = we && (addr[AW+1:2] < ROM_LIMIT);
        return bad_f3 || misaligned || out_of_range || rom_store;
    endfunction

    assign fault_s = lsu_fault(req_we, req_funct3, req_addr);

    // The memory word is both the load source and the old word for merges
    lsu_data_align u_align (
        .funct3     (funct3_r),
        .addr_lo    (addr_lo_r),
        .old_word   (mem_r_data),
        .wdata      (wdata_r),
        .rdata      (mem_r_data),
        .load_value (load_value_s),
        .store_word (store_word_s)
    );

    // Control FSM with registered memory strobes and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {RISC_V_DATA_WIDTH{1'b0}};
            rsp_fault_r   <= 1'b0;
            mem_address_r <= {AW{1'b0}};
            mem_w_data_r  <= {RISC_V_DATA_WIDTH{1'b0}};
            mem_w_r       <= 1'b0;
            mem_r_r       <= 1'b0;
            we_r          <= 1'b0;
            funct3_r      <= 3'b000;
            addr_lo_r     <= 2'b00;
            wdata_r       <= {RISC_V_DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid_r  <= 1'b0;
            mem_w_r      <= 1'b0;
            mem_r_r      <= 1'b0;
            mem_w_data_r <= {RISC_V_DATA_WIDTH{1'b0}};
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r          <= req_we;
                        funct3_r      <= req_funct3;
                        addr_lo_r     <= req_addr[1:0];
                        wdata_r       <= req_wdata;
                        mem_address_r <= req_addr[AW+1:2];
                        req_ready_r   <= 1'b0;
                        if (fault_s) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_fault_r <= 1'b1;
                            rsp_rdata_r <= {RISC_V_DATA_WIDTH{1'b0}};
                        end else if (!req_we || (req_funct3[1:0] != 2'b10)) begin
                            state_r <= READ;
                            mem_r_r <= 1'b1;
                        end else begin
                            state_r      <= WRITE;
                            mem_w_r      <= 1'b1;
                            mem_w_data_r <= req_wdata;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (we_r) begin
                        state_r      <= WRITE;
                        mem_w_r      <= 1'b1;
                        mem_w_data_r <= store_word_s;
                    end else begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_fault_r <= 1'b0;
                        rsp_rdata_r <= load_value_s;
                    end
                end
                WRITE: begin
                    state_r     <= RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= {RISC_V_DATA_WIDTH{1'b0}};
                end
                RESP: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_fault      = rsp_fault_r;
    assign mem_address    = mem_address_r;
    assign mem_w_data     = mem_w_data_r;
    assign mem_ctrl_mem_w = mem_w_r;
    assign mem_ctrl_mem_r = mem_r_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [9:0]  mem_address;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        mem_ctrl_mem_w;
    logic        mem_ctrl_mem_r;

    logic [31:0] mem [0:1023];
    logic        load_mem;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [9:0]  last_waddr;
    logic [31:0] last_wdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs[$];

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_address    (mem_address),
        .mem_w_data     (mem_w_data),
        .mem_r_data     (mem_r_data),
        .mem_ctrl_mem_w (mem_ctrl_mem_w),
        .mem_ctrl_mem_r (mem_ctrl_mem_r)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_address];

    always @(posedge clk) begin
        if (load_mem) begin
            mem[10'h100] <= 32'h11223344;
            mem[10'h101] <= 32'h89ABCDEF;
            mem[10'h3FF] <= 32'hCAFEF00D;
        end else if (mem_ctrl_mem_w) begin
            mem[mem_address] <= mem_w_data;
        end
    end

    always @(negedge clk) begin
        if (mem_ctrl_mem_w) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_address;
            last_wdata <= mem_w_data;
        end
        if (mem_ctrl_mem_r) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic fault, input int lat, input int nrd,
                                input int nwr, input logic [31:0] wword);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_fault = fault; v.exp_lat = lat;
        v.exp_rd = nrd; v.exp_wr = nwr; v.exp_wword = wword;
        return v;
    endfunction

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run_vec(input int id, input vec_t v);
        int lat;
        bit got;
        int wr0;
        int rd0;
        logic [9:0] exp_waddr;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        exp_waddr = v.addr[11:2];
        chk($sformatf("v%0d_ready_idle", id), {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        req_valid = 1'b0;
        chk($sformatf("v%0d_rsp_seen", id), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
        chk($sformatf("v%0d_rdata", id), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_fault", id), {31'd0, rsp_fault}, {31'd0, v.exp_fault});
        chk($sformatf("v%0d_ready_busy", id), {31'd0, req_ready}, 32'd0);
        chk($sformatf("v%0d_reads", id), rd_cnt - rd0, v.exp_rd);
        chk($sformatf("v%0d_writes", id), wr_cnt - wr0, v.exp_wr);
        if (v.exp_wr != 0) begin
            chk($sformatf("v%0d_waddr", id), {22'd0, last_waddr}, {22'd0, exp_waddr});
            chk($sformatf("v%0d_wdata", id), last_wdata, v.exp_wword);
        end
        @(negedge clk);
        chk($sformatf("v%0d_rsp_oneshot", id), {31'd0, rsp_valid}, 32'd0);
        chk($sformatf("v%0d_ready_back", id), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int wr0;
        int rsp_seen;
        rst        = 1'b0;
        load_mem   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        //        we    f3      addr          wdata          rdata          flt  lat rd wr  wword
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0400, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0400, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0401, 32'hAAAAAA12, 32'h00000000, 1'b0, 3, 1, 1, 32'hDEAD12EF));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0401, 32'h00000000, 32'h00000012, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0403, 32'h00000000, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0403, 32'h00000000, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0402, 32'h00000000, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0402, 32'h00000000, 32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0401, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0010, 32'h12345678, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0001_0000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0406, 32'hFFFF1234, 32'h00000000, 1'b0, 3, 1, 1, 32'h1234CDEF));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0404, 32'h00000000, 32'h1234CDEF, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0404, 32'h00000000, 32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0405, 32'h00000000, 32'h000000CD, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0404, 32'h00000000, 32'hFFFFCDEF, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0402, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0400, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0400, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_03FF, 32'h00000055, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0FFC, 32'h00000000, 32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_1000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0401, 32'h00005555, 32'h00000000, 1'b1, 1, 0, 0, 32'h0));

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_fault", {31'd0, rsp_fault}, 32'd0);
        chk("reset_mem_ctrl", {30'd0, mem_ctrl_mem_w, mem_ctrl_mem_r}, 32'd0);
        chk("reset_mem_address", {22'd0, mem_address}, 32'd0);
        chk("reset_mem_w_data", mem_w_data, 32'd0);

        // First request is presented in the same cycle reset deasserts
        load_mem = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during the READ cycle of SH 0x400 drops the request
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h0000_0400;
        req_wdata  = 32'h00005555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_read_active", {31'd0, mem_ctrl_mem_r}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_read_dropped", {31'd0, mem_ctrl_mem_r}, 32'd0);
        chk("rstmid_write_low", {31'd0, mem_ctrl_mem_w}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("rstmid_no_rsp", rsp_seen, 0);
        chk("rstmid_no_write", wr_cnt - wr0, 0);
        chk("rstmid_idle_ready", {31'd0, req_ready}, 32'd1);
        run_vec(99, mk(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hDEAD12EF, 1'b0, 2, 1, 0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
